step_dir_gen: RTL and testbench

- Downstream of acc_profile_gen. Consumes its per-step strobes: one strobe per crossing of the selected position bit, with direction.
- Produces driver-legal STEP/DIR waveforms with programmable DIR setup time, STEP high width and STEP low width.
- Buffers steps that arrive faster than the pulse timing allows in a signed net-pending counter.
- Maintains an emitted-step position count for host readback.

---
 rtl/step_dir_pkg.sv | 22 ++
 rtl/step_dir_gen_pulse_timer.sv | 31 +++
 rtl/step_dir_gen.sv | 175 +++++++++++++++++
 tb/tb_step_dir_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/step_dir_pkg.sv
// Shared types and default widths for the STEP/DIR pulse generator.
package step_dir_pkg;

    localparam int PEND_W_DEF = 8;
    localparam int TIM_W_DEF  = 16;
    localparam int POS_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    // Symmetric saturation magnitude of a signed counter of width w.
    function automatic int pend_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    localparam int PEND_MAX = pend_max(PEND_W_DEF);

endpackage

// File: rtl/step_dir_gen_pulse_timer.sv
// Loadable phase down-counter; a load of 0 behaves as 1, done marks the final cycle.
module pulse_timer
    import step_dir_pkg::*;
#(
    parameter int TIM_W = TIM_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TIM_W-1:0] load_val,
    output logic [TIM_W-1:0] count,
    output logic             done
);

    logic [TIM_W-1:0] count_r;

    // Counter register: load wins over decrement, parks at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= (load_val == '0) ? (TIM_W)'(1) : load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - (TIM_W)'(1);
        end
    end

    assign count = count_r;
    assign done  = (count_r == (TIM_W)'(1));

endmodule

// File: rtl/step_dir_gen.sv
// Turns step strobes into driver-legal STEP/DIR pulses, buffering excess steps.
module step_dir_gen
    import step_dir_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF,
    parameter int TIM_W  = TIM_W_DEF,
    parameter int POS_W  = POS_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_stb,
    input  logic             step_dir,
    input  logic             enable,
    input  logic             flush,
    input  logic             clr_ovf,
    input  logic [TIM_W-1:0] setup_cyc,
    input  logic [TIM_W-1:0] high_cyc,
    input  logic [TIM_W-1:0] low_cyc,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic             overflow,
    output logic [POS_W-1:0] position
);

    localparam int                      EXT_W    = PEND_W + 2;
    localparam logic signed [EXT_W-1:0] LIM_P    = (EXT_W)'(pend_max(PEND_W));
    localparam logic signed [EXT_W-1:0] LIM_N    = -LIM_P;
    localparam logic signed [EXT_W-1:0] ONE_EXT  = (EXT_W)'(1);
    localparam logic [POS_W-1:0]        POS_ONE  = (POS_W)'(1);

    state_t                    state_r, state_s;
    logic                      step_r, step_s;
    logic                      dir_r, dir_s;
    logic signed [PEND_W-1:0]  pend_r, pend_s;
    logic [POS_W-1:0]          pos_r;
    logic                      ovf_r, ovf_set_s;
    logic                      busy_r;
    logic                      commit_s;
    logic                      tmr_load_s, tmr_done_s;
    logic [TIM_W-1:0]          tmr_val_s, tmr_count_s;
    logic                      pend_pos_s, pend_neg_s;
    logic signed [EXT_W-1:0]   base_s, with_req_s;

    assign pend_neg_s = pend_r[PEND_W-1];
    assign pend_pos_s = !pend_r[PEND_W-1] && (pend_r != '0);

    pulse_timer #(.TIM_W(TIM_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .count    (tmr_count_s),
        .done     (tmr_done_s)
    );

    // Phase sequencing; DIR only ever changes on a cycle where STEP stays low.
    always_comb begin
        state_s    = state_r;
        step_s     = step_r;
        dir_s      = dir_r;
        commit_s   = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = high_cyc;
        case (state_r)
            IDLE: begin
                if (enable && (pend_pos_s || pend_neg_s)) begin
                    if (pend_pos_s == dir_r) begin
                        step_s     = 1'b1;
                        commit_s   = 1'b1;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = high_cyc;
                        state_s    = HIGH;
                    end else begin
                        dir_s      = pend_pos_s;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = setup_cyc;
                        state_s    = SETUP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (tmr_done_s) begin
                    if (dir_r ? pend_pos_s : pend_neg_s) begin
                        step_s     = 1'b1;
                        commit_s   = 1'b1;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = high_cyc;
                        state_s    = HIGH;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = SETUP;
                end
            end
            HIGH: begin
                if (tmr_done_s) begin
                    step_s     = 1'b0;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = low_cyc;
                    state_s    = LOW;
                end else begin
                    state_s = HIGH;
                end
            end
            LOW: begin
                if (tmr_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOW;
                end
            end
            default: begin
                state_s = IDLE;
                step_s  = 1'b0;
            end
        endcase
    end

    // Net pending: commit always applies; a request that would saturate is dropped.
    always_comb begin
        base_s     = EXT_W'(pend_r) - (commit_s ? (dir_r ? ONE_EXT : -ONE_EXT) : '0);
        with_req_s = base_s + (step_dir ? ONE_EXT : -ONE_EXT);
        ovf_set_s  = 1'b0;
        pend_s     = base_s[PEND_W-1:0];
        if (flush) begin
            pend_s = '0;
        end else if (step_stb) begin
            if ((with_req_s > LIM_P) || (with_req_s < LIM_N)) begin
                ovf_set_s = 1'b1;
            end else begin
                pend_s = with_req_s[PEND_W-1:0];
            end
        end else begin
            pend_s = base_s[PEND_W-1:0];
        end
    end

    // State, pins, pending, position and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            step_r  <= 1'b0;
            dir_r   <= 1'b0;
            pend_r  <= '0;
            pos_r   <= '0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            dir_r   <= dir_s;
            pend_r  <= pend_s;
            if (commit_s) begin
                pos_r <= dir_r ? (pos_r + POS_ONE) : (pos_r - POS_ONE);
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end
            busy_r <= (state_s != IDLE) || (pend_s != '0);
        end
    end

    assign step_out = step_r;
    assign dir_out  = dir_r;
    assign busy     = busy_r;
    assign overflow = ovf_r;
    assign position = pos_r;

endmodule

// File: tb/tb_step_dir_gen.sv
// Directed bench for step_dir_gen with hand-computed pulse timing and positions.
module tb_step_dir_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_stb, step_dir, enable, flush, clr_ovf;
    logic [15:0] setup_cyc, high_cyc, low_cyc;
    logic        step_out, dir_out, busy, overflow;
    logic [31:0] position;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_pos = 0;
    logic prev_step = 1'b0;
    int rise_q[$];

    step_dir_gen #(.PEND_W(4), .TIM_W(16), .POS_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .step_stb  (step_stb),
        .step_dir  (step_dir),
        .enable    (enable),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .setup_cyc (setup_cyc),
        .high_cyc  (high_cyc),
        .low_cyc   (low_cyc),
        .step_out  (step_out),
        .dir_out   (dir_out),
        .busy      (busy),
        .overflow  (overflow),
        .position  (position)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record the clock index of every STEP rising edge.
    always @(negedge clk) begin
        if (step_out && !prev_step) rise_q.push_back(cyc);
        prev_step = step_out;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic d);
        step_stb = 1'b1;
        step_dir = d;
        tick(1);
        step_stb = 1'b0;
    endtask

    initial begin
        reset = 1'b1; step_stb = 1'b0; step_dir = 1'b0; enable = 1'b1;
        flush = 1'b0; clr_ovf = 1'b0;
        setup_cyc = 16'd5; high_cyc = 16'd3; low_cyc = 16'd2;
        tick(2);
        check_val("rst_step", 32'(step_out), 32'd0);
        check_val("rst_dir",  32'(dir_out),  32'd0);
        check_val("rst_busy", 32'(busy),     32'd0);
        check_val("rst_ovf",  32'(overflow), 32'd0);
        check_val("rst_pos",  position,      32'd0);
        reset = 1'b0;
        tick(1);

        // dir 0 -> 1 with setup 5
        strobe(1'b1);
        tick(1);
        check_val("t0_dir",  32'(dir_out),  32'd1);
        check_val("t0_nostep", 32'(step_out), 32'd0);
        tick(4);
        check_val("t0_setup_hold", 32'(step_out), 32'd0);
        tick(1);
        check_val("t0_step", 32'(step_out), 32'd1);
        exp_pos = 1;
        check_val("t0_pos", position, 32'(exp_pos));
        tick(5);
        check_val("t0_idle", 32'(busy), 32'd0);

        // same direction, high 3 low 2
        strobe(1'b1);
        check_val("t1_busy", 32'(busy), 32'd1);
        tick(1);
        check_val("t1_rise", 32'(step_out), 32'd1);
        tick(2);
        check_val("t1_high3", 32'(step_out), 32'd1);
        tick(1);
        check_val("t1_fall", 32'(step_out), 32'd0);
        exp_pos = 2;
        check_val("t1_pos", position, 32'(exp_pos));
        tick(1);
        check_val("t1_busy_low", 32'(busy), 32'd1);
        tick(1);
        check_val("t1_busy_end", 32'(busy), 32'd0);

        // reversal with setup 5
        strobe(1'b0);
        tick(1);
        check_val("t2_dir", 32'(dir_out), 32'd0);
        check_val("t2_nostep", 32'(step_out), 32'd0);
        tick(4);
        check_val("t2_setup_hold", 32'(step_out), 32'd0);
        tick(1);
        check_val("t2_step", 32'(step_out), 32'd1);
        exp_pos = 1;
        check_val("t2_pos", position, 32'(exp_pos));
        tick(5);

        // five back-to-back strobes, high 10 low 10
        setup_cyc = 16'd2; high_cyc = 16'd10; low_cyc = 16'd10;
        rise_q.delete();
        for (int i = 0; i < 5; i++) strobe(1'b1);
        tick(130);
        check_val("t3_pulses", 32'(rise_q.size()), 32'd5);
        for (int i = 1; i < rise_q.size(); i++)
            check_val("t3_gap", 32'(rise_q[i] - rise_q[i-1]), 32'd21);
        exp_pos = 6;
        check_val("t3_pos", position, 32'(exp_pos));
        check_val("t3_ovf", 32'(overflow), 32'd0);
        check_val("t3_busy", 32'(busy), 32'd0);

        // saturation at +7 with 4-bit pending
        rise_q.delete();
        for (int i = 0; i < 10; i++) strobe(1'b1);
        check_val("t4_ovf_set", 32'(overflow), 32'd1);
        tick(200);
        check_val("t4_pulses", 32'(rise_q.size()), 32'd8);
        exp_pos = 14;
        check_val("t4_pos", position, 32'(exp_pos));
        check_val("t4_ovf_sticky", 32'(overflow), 32'd1);
        check_val("t4_busy", 32'(busy), 32'd0);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check_val("t4_ovf_clr", 32'(overflow), 32'd0);

        // net +2 buffered during HIGH, flush during the following pulse
        rise_q.delete();
        strobe(1'b1);
        tick(1);
        check_val("t5_first", 32'(step_out), 32'd1);
        strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b1);
        tick(19);
        check_val("t5_second", 32'(step_out), 32'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check_val("t5_completes", 32'(step_out), 32'd1);
        check_val("t5_busy_mid", 32'(busy), 32'd1);
        tick(25);
        check_val("t5_pulses", 32'(rise_q.size()), 32'd2);
        exp_pos = 16;
        check_val("t5_pos", position, 32'(exp_pos));
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_step", 32'(step_out), 32'd0);

        // asynchronous reset in the middle of a long HIGH phase
        high_cyc = 16'd50;
        for (int i = 0; i < 10; i++) strobe(1'b1);
        check_val("t6_pre_step", 32'(step_out), 32'd1);
        check_val("t6_pre_ovf", 32'(overflow), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_step", 32'(step_out), 32'd0);
        check_val("t6_pos",  position,      32'd0);
        check_val("t6_busy", 32'(busy),     32'd0);
        check_val("t6_ovf",  32'(overflow), 32'd0);
        check_val("t6_dir",  32'(dir_out),  32'd0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check_val("t6_after", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
